// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: board clock rate, default counter
// width and the terminal counts used by the stopwatch datapath.
package clk_div_pkg;

    localparam int unsigned SYS_CLK_HZ = 100_000_000;
    localparam int          CNT_W      = 27;

    // Terminal count for a tick rate of hz: the counter runs 0..TC, so TC+1 cycles per tick.
    function automatic logic [CNT_W-1:0] hz_to_tc(input int unsigned hz);
        return CNT_W'(SYS_CLK_HZ / hz - 1);
    endfunction

    // TC_1HZ names the blink rate of the level output, which toggles on every 2 Hz tick.
    localparam logic [CNT_W-1:0] TC_1HZ   = hz_to_tc(2);
    localparam logic [CNT_W-1:0] TC_4HZ   = hz_to_tc(4);
    localparam logic [CNT_W-1:0] TC_400HZ = hz_to_tc(400);

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, one-cycle tick strobe and 50%-duty level output.
// With CLK_DIV_BANK_RUNTIME_TC_EN defined the terminal count is a writable register.
module clk_div_channel #(
    parameter int               CNT_W   = clk_div_pkg::CNT_W,
    parameter logic [CNT_W-1:0] TC_INIT = '0
) (
    input  logic             internal_clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
    input  logic             tc_wr,
    input  logic [CNT_W-1:0] tc_data,
`endif
    output logic             tick,
    output logic             level
);

    import clk_div_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc;
    logic             tc_load;

`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
    logic [CNT_W-1:0] tc_q;

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q <= TC_INIT;
        end else if (tc_wr) begin
            tc_q <= tc_data;
        end
    end

    assign tc      = tc_q;
    assign tc_load = tc_wr;
`else
    assign tc      = TC_INIT;
    assign tc_load = 1'b0;
`endif

    // A TC write clears the count so cnt can never sit above a freshly lowered TC.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (tc_load) begin
            cnt   <= '0;
            tick  <= 1'b0;
        end else if (run) begin
            if (cnt == tc) begin
                cnt   <= '0;
                tick  <= 1'b1;
                level <= ~level;
            end else begin
                cnt   <= cnt + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock-enable dividers on internal_clk.
// Define CLK_DIV_BANK_RUNTIME_TC_EN to add the tc_wr/tc_sel/tc_data write port.
module clk_div_bank #(
    parameter int                        NUM_CH = 3,
    parameter int                        CNT_W  = clk_div_pkg::CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]   TC_VEC = {CNT_W'(clk_div_pkg::TC_4HZ),
                                                   CNT_W'(clk_div_pkg::TC_400HZ),
                                                   CNT_W'(clk_div_pkg::TC_1HZ)}
) (
    input  logic              internal_clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] run,
    input  logic [NUM_CH-1:0] restart,
`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
    input  logic              tc_wr,
    input  logic [2:0]        tc_sel,
    input  logic [CNT_W-1:0]  tc_data,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] level
);

    import clk_div_pkg::*;

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_num_ch_check
        $error("clk_div_bank: NUM_CH must be within 1..8");
    end

`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
    logic [NUM_CH-1:0] ch_wr;

    // tc_sel values at or above NUM_CH match no channel, so such writes are dropped.
    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tc_wr && (tc_sel == 3'(i))) begin
                ch_wr[i] = 1'b1;
            end
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W   (CNT_W),
            .TC_INIT (TC_VEC[i*CNT_W +: CNT_W])
        ) u_channel (
            .internal_clk (internal_clk),
            .rst_n        (rst_n),
            .run          (run[i]),
            .restart      (restart[i]),
`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
            .tc_wr        (ch_wr[i]),
            .tc_data      (tc_data),
`endif
            .tick         (tick[i]),
            .level        (level[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank with small terminal counts {3,1,0}.
// Runtime TC write checks are built only when CLK_DIV_BANK_RUNTIME_TC_EN is defined.
module tb_clk_div_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 27;
    localparam logic [NUM_CH*CNT_W-1:0] TC_VEC = {27'd3, 27'd1, 27'd0};

    logic              internal_clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] restart;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] level;
`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
    logic              tc_wr;
    logic [2:0]        tc_sel;
    logic [CNT_W-1:0]  tc_data;
`endif

    int check_count = 0;
    int error_count = 0;

    logic [2:0] exp_tick  [8] = '{3'b001, 3'b011, 3'b001, 3'b111,
                                  3'b001, 3'b011, 3'b001, 3'b111};
    logic [2:0] exp_level [8] = '{3'b001, 3'b010, 3'b011, 3'b100,
                                  3'b101, 3'b110, 3'b111, 3'b000};

    clk_div_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .TC_VEC (TC_VEC)
    ) dut (
        .internal_clk (internal_clk),
        .rst_n        (rst_n),
        .run          (run),
        .restart      (restart),
`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
        .tc_wr        (tc_wr),
        .tc_sel       (tc_sel),
        .tc_data      (tc_data),
`endif
        .tick         (tick),
        .level        (level)
    );

    always #5 internal_clk = ~internal_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next edge.
    task automatic applyStimulus(input logic [2:0] run_v, input logic [2:0] restart_v);
        run     = run_v;
        restart = restart_v;
        @(posedge internal_clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        run     = 3'b111;
        restart = 3'b000;
`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
        tc_wr   = 1'b0;
        tc_sel  = 3'd0;
        tc_data = '0;
`endif
        repeat (3) @(posedge internal_clk);
        #1;
        checkOutput("reset_tick", 32'(tick), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);

        @(negedge internal_clk);
        rst_n = 1'b1;
        #1;

        for (int k = 0; k < 8; k++) begin
            applyStimulus(3'b111, 3'b000);
            checkOutput($sformatf("rate_tick_%0d", k), 32'(tick), 32'(exp_tick[k]));
            checkOutput($sformatf("rate_level_%0d", k), 32'(level), 32'(exp_level[k]));
        end

        // ch2 ticks again on edge 12, then counts to 2 before the pause.
        repeat (4) applyStimulus(3'b111, 3'b000);
        checkOutput("pre_pause_tick2", 32'(tick[2]), 32'd1);
        checkOutput("pre_pause_level2", 32'(level[2]), 32'd1);
        repeat (2) applyStimulus(3'b111, 3'b000);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b011, 3'b000);
            checkOutput($sformatf("pause_tick2_%0d", k), 32'(tick[2]), 32'd0);
            checkOutput($sformatf("pause_level2_%0d", k), 32'(level[2]), 32'd1);
        end
        applyStimulus(3'b111, 3'b000);
        checkOutput("resume1_tick2", 32'(tick[2]), 32'd0);
        applyStimulus(3'b111, 3'b000);
        checkOutput("resume2_tick2", 32'(tick[2]), 32'd1);
        checkOutput("resume2_level2", 32'(level[2]), 32'd0);

        // Drive ch2 to level=1, cnt==3, then restart with run held high.
        repeat (4) applyStimulus(3'b111, 3'b000);
        checkOutput("period_tick2", 32'(tick[2]), 32'd1);
        checkOutput("period_level2", 32'(level[2]), 32'd1);
        repeat (3) applyStimulus(3'b111, 3'b000);
        checkOutput("at_tc_tick2", 32'(tick[2]), 32'd0);
        applyStimulus(3'b111, 3'b100);
        checkOutput("restart_tick2", 32'(tick[2]), 32'd0);
        checkOutput("restart_level2", 32'(level[2]), 32'd0);
        repeat (3) applyStimulus(3'b111, 3'b000);
        checkOutput("post_restart3_tick2", 32'(tick[2]), 32'd0);
        applyStimulus(3'b111, 3'b000);
        checkOutput("post_restart4_tick2", 32'(tick[2]), 32'd1);
        checkOutput("post_restart4_level2", 32'(level[2]), 32'd1);

        // Asynchronous reset between edges while level[2] is high.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tick", 32'(tick), 32'd0);
        checkOutput("async_reset_level", 32'(level), 32'd0);
        @(posedge internal_clk);
        #1;
        checkOutput("held_reset_level", 32'(level), 32'd0);
        @(negedge internal_clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b111, 3'b000);
            checkOutput($sformatf("rerun_tick_%0d", k), 32'(tick), 32'(exp_tick[k]));
            checkOutput($sformatf("rerun_level_%0d", k), 32'(level), 32'(exp_level[k]));
        end

`ifdef CLK_DIV_BANK_RUNTIME_TC_EN
        // ch1 sits at cnt==1==TC when the write lands, so a missed clear would tick.
        applyStimulus(3'b111, 3'b000);
        tc_wr   = 1'b1;
        tc_sel  = 3'd1;
        tc_data = 27'd5;
        applyStimulus(3'b111, 3'b000);
        tc_wr   = 1'b0;
        checkOutput("tc_write_tick1", 32'(tick[1]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b111, 3'b000);
            checkOutput($sformatf("tc5_wait_tick1_%0d", k), 32'(tick[1]), 32'd0);
        end
        applyStimulus(3'b111, 3'b000);
        checkOutput("tc5_tick1", 32'(tick[1]), 32'd1);

        tc_wr   = 1'b1;
        tc_sel  = 3'd7;
        tc_data = 27'd2;
        applyStimulus(3'b111, 3'b000);
        tc_wr   = 1'b0;
        checkOutput("bad_sel_tick0", 32'(tick[0]), 32'd1);
        checkOutput("bad_sel_tick1", 32'(tick[1]), 32'd0);
        repeat (3) applyStimulus(3'b111, 3'b000);
        checkOutput("bad_sel_wait_tick0", 32'(tick[0]), 32'd1);
        applyStimulus(3'b111, 3'b000);
        checkOutput("bad_sel_wait_tick1", 32'(tick[1]), 32'd0);
        applyStimulus(3'b111, 3'b000);
        checkOutput("bad_sel_next_tick1", 32'(tick[1]), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
